// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - fetch state encoding and shared fetch constants
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry skid register for a word fetched while IF/ID is stalled
module fetch_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_next_pc,
    output logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        full
);

    // flush beats load so a redirect in the same cycle never leaves a stale word behind
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr   <= '0;
            next_pc <= '0;
            full    <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            instr   <= load_instr;
            next_pc <= load_next_pc;
            full    <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and instruction-fetch stage feeding the IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] next_pc,
    output logic        valid
);

    import fetch_stage_pkg::*;

    fetch_state_e state, state_nx;
    logic         run;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  target, target_nx;
    logic [31:0]  ir_nx, next_pc_nx;
    logic         valid_nx;
    logic [31:0]  pc_plus4, branch_aligned;
    logic         hb_load, hb_drain, hb_flush, hb_full;
    logic [31:0]  hb_instr, hb_next_pc;

    assign pc_plus4       = pc + PC_INCR;
    assign branch_aligned = branch_target & 32'hFFFF_FFFC;
    // run keeps the request low for the first cycle out of reset
    assign imem_req       = ((state == FETCH) && run) || (state == SQUASH);
    assign imem_addr      = pc;

    fetch_hold_buf u_hold_buf (
        .clk          (clk),
        .reset        (reset),
        .load         (hb_load),
        .drain        (hb_drain),
        .flush        (hb_flush),
        .load_instr   (imem_data),
        .load_next_pc (pc_plus4),
        .instr        (hb_instr),
        .next_pc      (hb_next_pc),
        .full         (hb_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            target  <= '0;
            ir      <= NOP_INSTR;
            next_pc <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nx;
            run     <= 1'b1;
            pc      <= pc_nx;
            target  <= target_nx;
            ir      <= ir_nx;
            next_pc <= next_pc_nx;
            valid   <= valid_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        target_nx  = target;
        ir_nx      = ir;
        next_pc_nx = next_pc;
        valid_nx   = valid;
        hb_load    = 1'b0;
        hb_drain   = 1'b0;
        hb_flush   = 1'b0;

        if (take_branch) begin
            hb_flush  = 1'b1;
            valid_nx  = 1'b0;
            ir_nx     = NOP_INSTR;
            target_nx = branch_aligned;
            // an unfinished request must still complete at its old address
            if (imem_req && !imem_ready) begin
                state_nx = SQUASH;
            end else begin
                pc_nx    = branch_aligned;
                state_nx = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (run && imem_ready) begin
                        pc_nx = pc_plus4;
                        if (stall) begin
                            hb_load  = 1'b1;
                            state_nx = HOLD;
                        end else begin
                            ir_nx      = imem_data;
                            next_pc_nx = pc_plus4;
                            valid_nx   = 1'b1;
                        end
                    end else if (run && !stall) begin
                        valid_nx = 1'b0;
                        ir_nx    = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (hb_full) begin
                            ir_nx      = hb_instr;
                            next_pc_nx = hb_next_pc;
                            valid_nx   = 1'b1;
                        end
                        hb_drain = 1'b1;
                        state_nx = FETCH;
                    end
                end
                SQUASH: begin
                    if (imem_ready) begin
                        pc_nx    = target;
                        state_nx = FETCH;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        take_branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] next_pc;
    logic        valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // every address has a distinct, predictable word; 0x1000 -> A000_0001, 0x1004 -> A000_0002, ...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h0000_1000) >> 2) + 32'd1;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .ir            (ir),
        .next_pc       (next_pc),
        .valid         (valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_next;
    logic [31:0] prev_addr;
    logic        prev_req, prev_ready, have_prev;
    int          consumed;

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_ir", ir, 32'h0);
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        tick; tick;
        chk("rst_held_req", {31'b0, imem_req}, 32'd0);

        // zero-wait memory after release
        reset = 1'b1; imem_ready = 1'b1;
        chk("first_cycle_req", {31'b0, imem_req}, 32'd0);
        tick;
        chk("f0_req", {31'b0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h1000);
        tick;
        chk("f0_ir", ir, 32'hA000_0001);
        chk("f0_next_pc", next_pc, 32'h1004);
        chk("f0_valid", {31'b0, valid}, 32'd1);
        chk("f1_addr", imem_addr, 32'h1004);

        // two wait states at 0x1004
        imem_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tick;
            chk("wait_valid", {31'b0, valid}, 32'd0);
            chk("wait_ir", ir, 32'h0);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h1004);
        end
        imem_ready = 1'b1;
        tick;
        chk("f1_ir", ir, 32'hA000_0002);
        chk("f1_next_pc", next_pc, 32'h1008);
        chk("f2_addr", imem_addr, 32'h1008);

        // stall for three cycles while 0x1008 returns
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick;
            chk("stall_ir", ir, 32'hA000_0002);
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick;
        chk("drain_ir", ir, 32'hA000_0003);
        chk("drain_next_pc", next_pc, 32'h100C);
        chk("drain_valid", {31'b0, valid}, 32'd1);
        chk("after_drain_addr", imem_addr, 32'h100C);
        tick;
        chk("f3_ir", ir, 32'hA000_0004);
        chk("f4_addr", imem_addr, 32'h1010);

        // redirect while 0x1010 is outstanding; ready arrives two cycles later
        imem_ready = 1'b0; take_branch = 1'b1; branch_target = 32'h2003;
        tick;
        take_branch = 1'b0;
        chk("sq_valid", {31'b0, valid}, 32'd0);
        chk("sq_ir", ir, 32'h0);
        chk("sq_req", {31'b0, imem_req}, 32'd1);
        chk("sq_addr_hold", imem_addr, 32'h1010);
        tick;
        chk("sq_addr_hold2", imem_addr, 32'h1010);
        imem_ready = 1'b1;
        tick;
        chk("sq_discard_valid", {31'b0, valid}, 32'd0);
        chk("sq_target_addr", imem_addr, 32'h2000);
        tick;
        chk("tgt_ir", ir, mem_word(32'h2000));
        chk("tgt_next_pc", next_pc, 32'h2004);

        // redirect while the hold buffer is full
        stall = 1'b1;
        tick;
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_ir", ir, mem_word(32'h2000));
        take_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick;
        take_branch = 1'b0; stall = 1'b0;
        chk("hb_flush_valid", {31'b0, valid}, 32'd0);
        chk("hb_flush_ir", ir, 32'h0);
        chk("hb_flush_addr", imem_addr, 32'hFFFF_FFFC);
        tick;
        chk("wrap_ir", ir, mem_word(32'hFFFF_FFFC));
        chk("wrap_next_pc", next_pc, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset asserted mid-request
        imem_ready = 1'b0; stall = 1'b1;
        tick;
        chk("pre_rst_valid", {31'b0, valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, valid}, 32'd0);
        chk("async_rst_ir", ir, 32'h0);
        chk("async_rst_next_pc", next_pc, 32'h0);
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        tick; tick;
        reset = 1'b1; stall = 1'b0;
        chk("rel_req", {31'b0, imem_req}, 32'd0);
        tick;
        chk("restart_addr", imem_addr, 32'h1000);
        chk("restart_valid", {31'b0, valid}, 32'd0);
        tick;
        chk("restart_ir", ir, 32'hA000_0001);
        chk("restart_next_pc", next_pc, 32'h1004);

        // random phase: IF/ID must see one unbroken address stream between redirects
        exp_next = 32'h1004;
        have_prev = 1'b0;
        prev_req = 1'b0; prev_ready = 1'b0; prev_addr = '0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            stall         = ($urandom_range(0, 99) < 30);
            imem_ready    = $urandom_range(0, 1) == 1;
            take_branch   = ($urandom_range(0, 99) < 5);
            branch_target = $urandom;
            if (have_prev && prev_req && !prev_ready) begin
                chk("rnd_req_held", {31'b0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (imem_req)
                chk("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (valid && !stall && !take_branch) begin
                chk("rnd_next_pc", next_pc, exp_next);
                chk("rnd_ir", ir, mem_word(next_pc - 32'd4));
                exp_next = exp_next + 32'd4;
                consumed++;
            end
            if (take_branch)
                exp_next = (branch_target & 32'hFFFF_FFFC) + 32'd4;
            prev_req   = imem_req;
            prev_ready = imem_ready;
            prev_addr  = imem_addr;
            have_prev  = 1'b1;
            tick;
        end
        take_branch = 1'b0;
        chk("rnd_progress", {31'b0, consumed > 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
